bin2bcd_stream: RTL and testbench

//  Sequential shift-add-3 (double-dabble) binary-to-BCD converter with valid/ready handshakes.

---
 rtl/bin2bcd_stream.sv | 125 ++++++++++++
 tb/tb_bin2bcd_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_stream.sv
// bin2bcd_stream: sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Optional two's-complement input handling is enabled by defining BIN2BCD_SIGNED_EN.
module bin2bcd_stream #(
    parameter int pBitWidth = 16,
    parameter int pDigits   = 5
) (
    input  logic                         iClock,
    input  logic                         iReset,
    input  logic                         iValid,
    output logic                         oReady,
    input  logic [pBitWidth-1:0]         iBinary,
    output logic                         oValid,
    input  logic                         iReady,
    output logic [4*pDigits-1:0]         oBcd,
    output logic [$clog2(pDigits+1)-1:0] oNumDigits,
    output logic                         oOverflow,
    output logic                         oSign
);
    localparam int CW = $clog2(pBitWidth + 1);
    localparam int NW = $clog2(pDigits + 1);
    localparam int BW = 4 * pDigits;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state_q, state_d;
    logic [pBitWidth-1:0] sr_q, sr_d, sr_sh, mag;
    logic [BW-1:0]        dig_q, dig_d, dig_sh, adj;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NW-1:0]        nd_q, nd_d, nz;
    logic                 ovf_q, ovf_d, ovf_sh;
    logic                 ovo_q, ovo_d;

    for (genvar g = 0; g < pDigits; g++) begin : g_adj
        assign adj[4*g +: 4] = dig_q[4*g +: 4] >= 4'd5 ? dig_q[4*g +: 4] + 4'd3 : dig_q[4*g +: 4];
    end

`ifdef BIN2BCD_SIGNED_EN
    logic sgn_q, sgn_d, osg_q, osg_d;
    assign mag   = iBinary[pBitWidth-1] ? -iBinary : iBinary;
    assign sgn_d = (state_q == IDLE && iValid) ? iBinary[pBitWidth-1] : sgn_q;
    assign osg_d = (state_q == SHIFT && cnt_q == CW'(1)) ? sgn_q : osg_q;
    assign oSign = osg_q;
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            sgn_q <= 1'b0;
            osg_q <= 1'b0;
        end else begin
            sgn_q <= sgn_d;
            osg_q <= osg_d;
        end
    end
`else
    assign mag   = iBinary;
    assign oSign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        nd_d    = nd_q;
        ovo_d   = ovo_q;
        {dig_sh, sr_sh} = {adj, sr_q} << 1;
        // a set bit 3 in the top digit is about to be shifted out of the digit field
        ovf_sh  = ovf_q | adj[BW-1];
        nz      = NW'(1);
        for (int i = 0; i < pDigits; i++)
            if (dig_sh[4*i +: 4] != 4'd0) nz = NW'(i + 1);
        case (state_q)
            IDLE: if (iValid) begin
                sr_d    = mag;
                dig_d   = '0;
                ovf_d   = 1'b0;
                cnt_d   = CW'(pBitWidth);
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d  = sr_sh;
                dig_d = dig_sh;
                ovf_d = ovf_sh;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    bcd_d   = dig_sh;
                    ovo_d   = ovf_sh;
                    nd_d    = ovf_sh ? NW'(pDigits) : nz;
                end
            end
            DONE: state_d = iReady ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            nd_q    <= '0;
            ovo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            nd_q    <= nd_d;
            ovo_q   <= ovo_d;
        end
    end

    assign oReady     = state_q == IDLE;
    assign oValid     = state_q == DONE;
    assign oBcd       = bcd_q;
    assign oNumDigits = nd_q;
    assign oOverflow  = ovo_q;
endmodule

// File: tb/tb_bin2bcd_stream.sv
// tb_bin2bcd_stream: directed checks of bin2bcd_stream at W=16 with 5-digit and 4-digit instances.
module tb_bin2bcd_stream;
    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic        iValid = 1'b0;
    logic        iReady = 1'b0;
    logic [15:0] iBinary = '0;
    logic        oReady, oValid, oOverflow, oSign;
    logic [19:0] oBcd;
    logic [2:0]  oNumDigits;
    logic        rdy4, val4, ovf4, sgn4;
    logic [15:0] bcd4;
    logic [2:0]  nd4;
    int          n_chk = 0;
    int          n_fail = 0;
    int          lat;

    always #5 iClock = ~iClock;

    bin2bcd_stream #(.pBitWidth(16), .pDigits(5)) u_dut (
        .iClock(iClock), .iReset(iReset), .iValid(iValid), .oReady(oReady), .iBinary(iBinary),
        .oValid(oValid), .iReady(iReady), .oBcd(oBcd), .oNumDigits(oNumDigits),
        .oOverflow(oOverflow), .oSign(oSign)
    );

    bin2bcd_stream #(.pBitWidth(16), .pDigits(4)) u_d4 (
        .iClock(iClock), .iReset(iReset), .iValid(iValid), .oReady(rdy4), .iBinary(iBinary),
        .oValid(val4), .iReady(iReady), .oBcd(bcd4), .oNumDigits(nd4),
        .oOverflow(ovf4), .oSign(sgn4)
    );

    task automatic accept(input logic [15:0] v);
        int g = 0;
        while (!oReady && g < 50) begin
            @(posedge iClock); #1;
            g++;
        end
        iValid  = 1'b1;
        iBinary = v;
        @(posedge iClock); #1;
        iValid  = 1'b0;
        iBinary = 16'hDEAD;
    endtask

    task automatic wait_result(output int l);
        l = 0;
        while (!oValid && l < 100) begin
            @(posedge iClock); #1;
            l++;
        end
    endtask

    task automatic release_result();
        iReady = 1'b1;
        @(posedge iClock); #1;
        iReady = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++;
        if (oValid !== 1'b0 || oBcd !== 20'h0 || oNumDigits !== 3'd0 || oOverflow !== 1'b0 || oSign !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b bcd=%h nd=%0d ovf=%b sgn=%b, want all 0", oValid, oBcd, oNumDigits, oOverflow, oSign);
        end
        @(posedge iClock); #1;
        iReset = 1'b0;
        @(posedge iClock); #1;
        n_chk++;
        if (oReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", oReady);
        end
    endtask

    task automatic test_zero();
        accept(16'd0);
        wait_result(lat);
        n_chk++;
        if (lat !== 16) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d want 16", lat);
        end
        n_chk++;
        if (oBcd !== 20'h00000 || oNumDigits !== 3'd1 || oOverflow !== 1'b0 || oSign !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_result: got bcd=%h nd=%0d ovf=%b sgn=%b want 00000/1/0/0", oBcd, oNumDigits, oOverflow, oSign);
        end
        release_result();
    endtask

    task automatic test_max();
        accept(16'd65535);
        wait_result(lat);
        n_chk++;
        if (oBcd !== 20'h65535 || oNumDigits !== 3'd5 || oOverflow !== 1'b0) begin
            n_fail++;
            $display("FAIL max_result: got bcd=%h nd=%0d ovf=%b want 65535/5/0", oBcd, oNumDigits, oOverflow);
        end
        release_result();
    endtask

    task automatic test_overflow();
        accept(16'd12345);
        wait_result(lat);
        n_chk++;
        if (oBcd !== 20'h12345 || oNumDigits !== 3'd5 || oOverflow !== 1'b0) begin
            n_fail++;
            $display("FAIL d5_12345: got bcd=%h nd=%0d ovf=%b want 12345/5/0", oBcd, oNumDigits, oOverflow);
        end
        n_chk++;
        if (val4 !== 1'b1 || bcd4 !== 16'h2345 || nd4 !== 3'd4 || ovf4 !== 1'b1) begin
            n_fail++;
            $display("FAIL d4_overflow: got v=%b bcd=%h nd=%0d ovf=%b want 1/2345/4/1", val4, bcd4, nd4, ovf4);
        end
        release_result();
        n_chk++;
        if (oValid !== 1'b0 || oBcd !== 20'h12345) begin
            n_fail++;
            $display("FAIL hold_after_handshake: got v=%b bcd=%h want 0/12345", oValid, oBcd);
        end
    endtask

    task automatic test_backpressure();
        accept(16'd907);
        wait_result(lat);
        for (int c = 0; c < 10; c++) begin
            iValid  = c[0];
            iBinary = 16'd1111;
            n_chk++;
            if (oValid !== 1'b1 || oReady !== 1'b0 || oBcd !== 20'h00907 || oNumDigits !== 3'd3) begin
                n_fail++;
                $display("FAIL backpressure_%0d: got v=%b r=%b bcd=%h nd=%0d want 1/0/00907/3", c, oValid, oReady, oBcd, oNumDigits);
            end
            @(posedge iClock); #1;
        end
        iValid = 1'b0;
        n_chk++;
        if (bcd4 !== 16'h0907 || nd4 !== 3'd3 || ovf4 !== 1'b0) begin
            n_fail++;
            $display("FAIL d4_907: got bcd=%h nd=%0d ovf=%b want 0907/3/0", bcd4, nd4, ovf4);
        end
        release_result();
        n_chk++;
        if (oReady !== 1'b1 || oValid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: got r=%b v=%b want 1/0", oReady, oValid);
        end
    endtask

    task automatic test_back_to_back();
        accept(16'd1234);
        wait_result(lat);
        n_chk++;
        if (oBcd !== 20'h01234 || oNumDigits !== 3'd4) begin
            n_fail++;
            $display("FAIL b2b_first: got bcd=%h nd=%0d want 01234/4", oBcd, oNumDigits);
        end
        iReady  = 1'b1;
        iValid  = 1'b1;
        iBinary = 16'd5678;
        @(posedge iClock); #1;
        iReady = 1'b0;
        n_chk++;
        if (oReady !== 1'b1 || oValid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got r=%b v=%b want 1/0", oReady, oValid);
        end
        @(posedge iClock); #1;
        iValid  = 1'b0;
        iBinary = 16'hDEAD;
        wait_result(lat);
        n_chk++;
        if (lat !== 16 || oBcd !== 20'h05678 || oNumDigits !== 3'd4) begin
            n_fail++;
            $display("FAIL b2b_second: got lat=%0d bcd=%h nd=%0d want 16/05678/4", lat, oBcd, oNumDigits);
        end
        release_result();
    endtask

    task automatic test_reset_midshift();
        int seen = 0;
        accept(16'd4321);
        repeat (7) begin
            @(posedge iClock); #1;
        end
        iReset = 1'b1;
        #1;
        n_chk++;
        if (oValid !== 1'b0 || oBcd !== 20'h0 || oNumDigits !== 3'd0 || oOverflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midshift_clear: got v=%b bcd=%h nd=%0d ovf=%b want 0/0/0/0", oValid, oBcd, oNumDigits, oOverflow);
        end
        @(posedge iClock); #1;
        iReset = 1'b0;
        repeat (20) begin
            @(posedge iClock); #1;
            if (oValid) seen++;
        end
        n_chk++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midshift_no_valid: got %0d valid cycles want 0", seen);
        end
        accept(16'd42);
        wait_result(lat);
        n_chk++;
        if (lat !== 16 || oBcd !== 20'h00042 || oNumDigits !== 3'd2) begin
            n_fail++;
            $display("FAIL after_reset_42: got lat=%0d bcd=%h nd=%0d want 16/00042/2", lat, oBcd, oNumDigits);
        end
        release_result();
    endtask

`ifdef BIN2BCD_SIGNED_EN
    task automatic test_signed();
        accept(16'hFFFF);
        wait_result(lat);
        n_chk++;
        if (oSign !== 1'b1 || oBcd !== 20'h00001 || oNumDigits !== 3'd1 || oOverflow !== 1'b0) begin
            n_fail++;
            $display("FAIL signed_m1: got sgn=%b bcd=%h nd=%0d ovf=%b want 1/00001/1/0", oSign, oBcd, oNumDigits, oOverflow);
        end
        release_result();
        accept(16'h8000);
        wait_result(lat);
        n_chk++;
        if (oSign !== 1'b1 || oBcd !== 20'h32768 || oNumDigits !== 3'd5 || oOverflow !== 1'b0) begin
            n_fail++;
            $display("FAIL signed_min: got sgn=%b bcd=%h nd=%0d ovf=%b want 1/32768/5/0", oSign, oBcd, oNumDigits, oOverflow);
        end
        release_result();
        accept(16'd300);
        wait_result(lat);
        n_chk++;
        if (oSign !== 1'b0 || oBcd !== 20'h00300) begin
            n_fail++;
            $display("FAIL signed_pos: got sgn=%b bcd=%h want 0/00300", oSign, oBcd);
        end
        release_result();
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_zero();
`ifdef BIN2BCD_SIGNED_EN
        test_signed();
`else
        test_max();
`endif
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_midshift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
